// File: rtl/jtopl_eg_rate_seq.sv
// Envelope rate/step sequencer: global EG counter plus a 2-stage per-slot rate/step pipeline.
// Optional counter preload ports are enabled by defining JTOPL_EGCNT_LOAD_EN.
module jtopl_eg_rate_seq #(
  parameter int unsigned SLOTS  = 18,
  parameter int unsigned CNTW   = 16,
  parameter int unsigned KSR_HI = 1,
  parameter int unsigned KSR_LO = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            cen_i,
  input  logic            zero_i,
  input  logic            in_valid_i,
  input  logic            attack_i,
  input  logic [4:0]      base_rate_i,
  input  logic [3:0]      keycode_i,
  input  logic            ksr_i,
`ifdef JTOPL_EGCNT_LOAD_EN
  input  logic            cnt_load_i,
  input  logic [CNTW-1:0] cnt_din_i,
`endif
  output logic            out_valid_o,
  output logic [5:0]      slot_out_o,
  output logic [5:0]      rate_o,
  output logic            step_o,
  output logic            sum_up_o,
  output logic [CNTW-1:0] eg_cnt_o
);

  localparam logic [5:0] SlotLast = 6'(SLOTS - 1);

  logic [5:0]      slot_q, slot_d, cur_slot;
  logic            sweep_end;
  logic [CNTW-1:0] eg_cnt_q, eg_cnt_d, carry_q, carry_d, ones;
  logic            run;

  logic            s1_valid_q, s1_attack_q;
  logic [5:0]      s1_slot_q, s1_rate_q;
  logic [3:0]      kc_sh;
  logic [6:0]      pre_rate;
  logic [5:0]      rate1;

  logic [3:0]      g;
  logic [CNTW-1:0] cnt_sh, carry_sh;
  logic [2:0]      cnt;
  logic [7:0]      pattern;
  logic            step2, sum2;

  logic            out_valid_q, step_q, sum_up_q;
  logic [5:0]      slot_out_q, rate_q;

  // zero tags the current slot as 0, so the counter resumes at 1 next cycle
  always_comb begin
    sweep_end = (slot_q == SlotLast);
    cur_slot  = zero_i ? 6'd0 : slot_q;
    if (zero_i)         slot_d = 6'd1;
    else if (sweep_end) slot_d = 6'd0;
    else                slot_d = slot_q + 6'd1;
  end

  // ones[i]: bits [i:0] of the counter are all set before the increment
  always_comb begin
    run  = 1'b1;
    ones = '0;
    for (int i = 0; i < int'(CNTW); i++) begin
      run     = run & eg_cnt_q[i];
      ones[i] = run;
    end
  end

  always_comb begin
    eg_cnt_d = eg_cnt_q;
    carry_d  = carry_q;
    if (sweep_end) begin
      eg_cnt_d = eg_cnt_q + CNTW'(1);
      carry_d  = ones;
    end
`ifdef JTOPL_EGCNT_LOAD_EN
    if (cnt_load_i) begin
      eg_cnt_d = cnt_din_i;
      carry_d  = '0;
    end
`endif
  end

  // Stage 1: effective rate with key scaling, saturated at 63
  always_comb begin
    kc_sh    = ksr_i ? (keycode_i >> KSR_HI) : (keycode_i >> KSR_LO);
    pre_rate = (base_rate_i == 5'd0) ? 7'd0 : ({1'b0, base_rate_i, 1'b0} + {3'd0, kc_sh});
    rate1    = (pre_rate >= 7'd60) ? 6'd63 : pre_rate[5:0];
  end

  // Stage 2: select counter phase and sweep carry per rate group
  always_comb begin
    g        = s1_rate_q[5:2];
    cnt_sh   = eg_cnt_q >> (4'd10 - g);
    carry_sh = carry_q >> (4'd9 - g);
    if (g == 4'd0) begin
      cnt  = 3'd0;
      sum2 = 1'b0;
    end else if (g <= 4'd9) begin
      cnt  = cnt_sh[2:0];
      sum2 = carry_sh[0];
    end else if (g <= 4'd14) begin
      cnt  = eg_cnt_q[2:0];
      sum2 = 1'b1;
    end else begin
      cnt  = 3'd7;
      sum2 = 1'b1;
    end

    if (g >= 4'd12) begin
      if (s1_attack_q && g == 4'd15) pattern = 8'hFF;
      else begin
        case (s1_rate_q[1:0])
          2'd0:    pattern = 8'h00;
          2'd1:    pattern = 8'h88;
          2'd2:    pattern = 8'hAA;
          default: pattern = 8'hEE;
        endcase
      end
    end else begin
      if (g == 4'd0 && !s1_attack_q) pattern = 8'hFE;
      else begin
        case (s1_rate_q[1:0])
          2'd0:    pattern = 8'hAA;
          2'd1:    pattern = 8'hEA;
          2'd2:    pattern = 8'hEE;
          default: pattern = 8'hFE;
        endcase
      end
    end
    step2 = pattern[cnt];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_q      <= '0;
      eg_cnt_q    <= '0;
      carry_q     <= '0;
      s1_valid_q  <= 1'b0;
      s1_attack_q <= 1'b0;
      s1_slot_q   <= '0;
      s1_rate_q   <= '0;
      out_valid_q <= 1'b0;
      slot_out_q  <= '0;
      rate_q      <= '0;
      step_q      <= 1'b0;
      sum_up_q    <= 1'b0;
    end else if (cen_i) begin
      slot_q      <= slot_d;
      eg_cnt_q    <= eg_cnt_d;
      carry_q     <= carry_d;
      s1_valid_q  <= in_valid_i;
      s1_attack_q <= attack_i;
      s1_slot_q   <= cur_slot;
      s1_rate_q   <= rate1;
      out_valid_q <= s1_valid_q;
      // bubbles leave the previous result on the outputs
      if (s1_valid_q) begin
        slot_out_q <= s1_slot_q;
        rate_q     <= s1_rate_q;
        step_q     <= step2;
        sum_up_q   <= sum2;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign slot_out_o  = slot_out_q;
  assign rate_o      = rate_q;
  assign step_o      = step_q;
  assign sum_up_o    = sum_up_q;
  assign eg_cnt_o    = eg_cnt_q;

endmodule
